// File: rtl/lbp_engine_param.sv
// Parametrised 3x3 Local Binary Pattern engine: streams a grey image, writes one code per interior pixel.
// Optional `LBP_BORDER_ZERO_EN` additionally writes 0 to every border pixel after the interior pass.
module lbp_engine_param #(
  parameter int IMG_W  = 128,
  parameter int IMG_H  = 128,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              gray_ready,
  output logic              gray_req,
  output logic [ADDR_W-1:0] gray_addr,
  input  logic [DATA_W-1:0] gray_data,
  input  logic              lbp_ready,
  output logic              lbp_valid,
  output logic [ADDR_W-1:0] lbp_addr,
  output logic [7:0]        lbp_data,
  output logic              finish
);

  localparam int LOG2_W = $clog2(IMG_W);
  localparam int ROW_W  = ADDR_W - LOG2_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_SHIFT,
    S_CALC,
    S_WRITE,
`ifdef LBP_BORDER_ZERO_EN
    S_BORDER,
`endif
    S_DONE
  } state_t;

  state_t              r_state;
  logic [ROW_W-1:0]    r_win_row;
  logic [LOG2_W-1:0]   r_win_col;
  logic [1:0]          r_rd_roff;
  logic [1:0]          r_rd_coff;
  logic                r_cap_vld;
  logic [1:0]          r_cap_roff;
  logic [1:0]          r_cap_coff;
  logic [DATA_W-1:0]   r_pix [3][3];

  logic                w_accept;
  logic                w_rd_last;
  logic                w_cap_last;
  logic                w_hs;
  logic                w_row_end;
  logic                w_last_row;
  logic                w_shift;
  logic [1:0]          w_nxt_roff;
  logic [1:0]          w_nxt_coff;
  logic [7:0]          w_code;

  function automatic logic [ADDR_W-1:0] f_addr(input logic [ROW_W-1:0] row,
                                               input logic [LOG2_W-1:0] col);
    return {row, col};
  endfunction

  assign w_accept   = gray_req & gray_ready;
  assign w_rd_last  = (r_rd_roff == 2'd2) && (r_rd_coff == 2'd2);
  assign w_cap_last = r_cap_vld && (r_cap_roff == 2'd2) && (r_cap_coff == 2'd2);
  assign w_hs       = lbp_valid & lbp_ready;
  assign w_row_end  = (r_win_col == LOG2_W'(IMG_W - 3));
  assign w_last_row = (r_win_row == ROW_W'(IMG_H - 3));
  assign w_shift    = (r_state == S_WRITE) && w_hs && !w_row_end;

  // Read order inside the window: raster over 3x3 in FILL, right column top-down in SHIFT.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    w_nxt_roff = r_rd_roff;
    w_nxt_coff = r_rd_coff + 2'd1;
    if (r_state == S_SHIFT) begin
      w_nxt_roff = r_rd_roff + 2'd1;
      w_nxt_coff = 2'd2;
    end else if (r_rd_coff == 2'd2) begin
      w_nxt_roff = r_rd_roff + 2'd1;
      w_nxt_coff = 2'd0;
    end
  end

  // Bit order: TL, T, TR, L, R, BL, B, BR; neighbour >= centre sets the bit.
  always_comb begin
    w_code    = '0;
    w_code[0] = r_pix[0][0] >= r_pix[1][1];
    w_code[1] = r_pix[0][1] >= r_pix[1][1];
    w_code[2] = r_pix[0][2] >= r_pix[1][1];
    w_code[3] = r_pix[1][0] >= r_pix[1][1];
    w_code[4] = r_pix[1][2] >= r_pix[1][1];
    w_code[5] = r_pix[2][0] >= r_pix[1][1];
    w_code[6] = r_pix[2][1] >= r_pix[1][1];
    w_code[7] = r_pix[2][2] >= r_pix[1][1];
  end

`ifdef LBP_BORDER_ZERO_EN
  logic [ROW_W-1:0]  r_bd_row;
  logic [LOG2_W-1:0] r_bd_col;
  logic [ROW_W-1:0]  w_bd_nxt_row;
  logic [LOG2_W-1:0] w_bd_nxt_col;
  logic              w_bd_last;

  // Border walk in raster order: full top/bottom rows, only first/last column in between.
  always_comb begin
    w_bd_nxt_row = r_bd_row;
    w_bd_nxt_col = r_bd_col + LOG2_W'(1);
    w_bd_last    = (r_bd_row == ROW_W'(IMG_H - 1)) && (r_bd_col == LOG2_W'(IMG_W - 1));
    if (r_bd_col == LOG2_W'(IMG_W - 1)) begin
      w_bd_nxt_row = r_bd_row + ROW_W'(1);
      w_bd_nxt_col = '0;
    end else if ((r_bd_row != '0) && (r_bd_row != ROW_W'(IMG_H - 1))) begin
      w_bd_nxt_col = LOG2_W'(IMG_W - 1);
    end
  end
`endif

  // NOTE: the pixel window is pure datapath and deliberately has no reset; every CALC is
  // preceded by a complete refill or shift+refill, so stale contents are never used.
  always_ff @(posedge clk) begin
    if (w_shift) begin
      for (int i = 0; i < 3; i++) begin
        r_pix[i][0] <= r_pix[i][1];
        r_pix[i][1] <= r_pix[i][2];
      end
    end
    if (r_cap_vld) begin
      r_pix[r_cap_roff][r_cap_coff] <= gray_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      gray_req   <= 1'b0;
      gray_addr  <= '0;
      lbp_valid  <= 1'b0;
      lbp_addr   <= '0;
      lbp_data   <= '0;
      finish     <= 1'b0;
      r_win_row  <= '0;
      r_win_col  <= '0;
      r_rd_roff  <= '0;
      r_rd_coff  <= '0;
      r_cap_vld  <= 1'b0;
      r_cap_roff <= '0;
      r_cap_coff <= '0;
`ifdef LBP_BORDER_ZERO_EN
      r_bd_row   <= '0;
      r_bd_col   <= '0;
`endif
    end else begin
      r_cap_vld <= w_accept;
      if (w_accept) begin
        r_cap_roff <= r_rd_roff;
        r_cap_coff <= r_rd_coff;
      end

      case (r_state)
        S_IDLE: begin
          if (gray_ready) begin
            r_state   <= S_FILL;
            gray_req  <= 1'b1;
            gray_addr <= f_addr(r_win_row, r_win_col);
            r_rd_roff <= 2'd0;
            r_rd_coff <= 2'd0;
          end
        end

        S_FILL, S_SHIFT: begin
          if (w_accept) begin
            r_rd_roff <= w_nxt_roff;
            r_rd_coff <= w_nxt_coff;
            if (w_rd_last) begin
              gray_req <= 1'b0;
            end else begin
              gray_addr <= f_addr(r_win_row + ROW_W'(w_nxt_roff),
                                  r_win_col + LOG2_W'(w_nxt_coff));
            end
          end
          if (w_cap_last) begin
            r_state <= S_CALC;
          end
        end

        S_CALC: begin
          lbp_data  <= w_code;
          lbp_addr  <= f_addr(r_win_row + ROW_W'(1), r_win_col + LOG2_W'(1));
          lbp_valid <= 1'b1;
          r_state   <= S_WRITE;
        end

        S_WRITE: begin
          if (lbp_ready) begin
            lbp_valid <= 1'b0;
            if (!w_row_end) begin
              r_win_col <= r_win_col + LOG2_W'(1);
              r_state   <= S_SHIFT;
              gray_req  <= 1'b1;
              gray_addr <= f_addr(r_win_row, r_win_col + LOG2_W'(3));
              r_rd_roff <= 2'd0;
              r_rd_coff <= 2'd2;
            end else if (!w_last_row) begin
              r_win_col <= '0;
              r_win_row <= r_win_row + ROW_W'(1);
              r_state   <= S_FILL;
              gray_req  <= 1'b1;
              gray_addr <= f_addr(r_win_row + ROW_W'(1), '0);
              r_rd_roff <= 2'd0;
              r_rd_coff <= 2'd0;
            end else begin
`ifdef LBP_BORDER_ZERO_EN
              r_state  <= S_BORDER;
              r_bd_row <= '0;
              r_bd_col <= '0;
`else
              r_state  <= S_DONE;
              finish   <= 1'b1;
`endif
            end
          end
        end

`ifdef LBP_BORDER_ZERO_EN
        S_BORDER: begin
          if (!lbp_valid) begin
            lbp_valid <= 1'b1;
            lbp_data  <= '0;
            lbp_addr  <= f_addr(r_bd_row, r_bd_col);
          end else if (lbp_ready) begin
            if (w_bd_last) begin
              lbp_valid <= 1'b0;
              r_state   <= S_DONE;
              finish    <= 1'b1;
            end else begin
              r_bd_row <= w_bd_nxt_row;
              r_bd_col <= w_bd_nxt_col;
              lbp_addr <= f_addr(w_bd_nxt_row, w_bd_nxt_col);
            end
          end
        end
`endif

        S_DONE: begin
          finish    <= 1'b1;
          gray_req  <= 1'b0;
          lbp_valid <= 1'b0;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_engine_param.sv
// Randomised self-checking bench for lbp_engine_param at 8x8, with a behavioural LBP reference model.
// Border-zero writes are expected when LBP_BORDER_ZERO_EN is defined.
module tb_lbp_engine_param;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 6;

  logic          clk;
  logic          reset_n;
  logic          gray_ready;
  logic          gray_req;
  logic [AW-1:0] gray_addr;
  logic [7:0]    gray_data;
  logic          lbp_ready;
  logic          lbp_valid;
  logic [AW-1:0] lbp_addr;
  logic [7:0]    lbp_data;
  logic          finish;

  lbp_engine_param #(.IMG_W(W), .IMG_H(H), .DATA_W(8), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .gray_ready (gray_ready),
    .gray_req   (gray_req),
    .gray_addr  (gray_addr),
    .gray_data  (gray_data),
    .lbp_ready  (lbp_ready),
    .lbp_valid  (lbp_valid),
    .lbp_addr   (lbp_addr),
    .lbp_data   (lbp_data),
    .finish     (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int a;
    int d;
  } wr_t;

  logic [7:0] img [W*H];
  wr_t        exp_q [$];
  int         acc_q [$];
  int         n_exp;

  int n_tests = 0;
  int n_fail  = 0;

  // Monitor / driver state
  int   g_mode = 0;      // 0: always ready, 1: random, 2: toggle
  int   l_mode = 0;      // 0: always ready, 1: random
  bit   stall_mode = 0;
  int   wr_count = 0;
  int   first_data = -1;
  int   hold_viol = 0;
  int   pend_viol = 0;
  int   stall_cnt = 0;
  int   stall_viol = 0;
  int   s_addr = -1;
  int   s_data = -1;
  bit   prev_pend = 0;
  int   prev_addr = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Source RAM: data one cycle after acceptance, garbage otherwise.
  always @(posedge clk) begin
    if (gray_req && gray_ready) gray_data <= img[gray_addr];
    else                        gray_data <= 8'($urandom);
  end

  function automatic int lbp_ref(input int r, input int c);
    int dr [8] = '{0, 0, 0, 1, 1, 2, 2, 2};
    int dc [8] = '{0, 1, 2, 0, 2, 0, 1, 2};
    int centre = int'(img[(r + 1) * W + c + 1]);
    int code = 0;
    for (int k = 0; k < 8; k++)
      if (int'(img[(r + dr[k]) * W + c + dc[k]]) >= centre) code += (1 << k);
    return code;
  endfunction

  task automatic build_expect();
    wr_t e;
    exp_q.delete();
    for (int r = 0; r <= H - 3; r++)
      for (int c = 0; c <= W - 3; c++) begin
        e.a = (r + 1) * W + c + 1;
        e.d = lbp_ref(r, c);
        exp_q.push_back(e);
      end
`ifdef LBP_BORDER_ZERO_EN
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) begin
          e.a = r * W + c;
          e.d = 0;
          exp_q.push_back(e);
        end
`endif
    n_exp = exp_q.size();
  endtask

  task automatic clear_mon();
    wr_count = 0; first_data = -1; hold_viol = 0; pend_viol = 0;
    stall_cnt = 0; stall_viol = 0; s_addr = -1; s_data = -1;
    prev_pend = 0; acc_q.delete();
  endtask

  // Drive readies on the falling edge, then sample outputs 1 time unit later.
  initial begin
    gray_ready = 1'b1;
    lbp_ready  = 1'b1;
    forever begin
      @(negedge clk);
      case (g_mode)
        0:       gray_ready = 1'b1;
        1:       gray_ready = 1'($urandom_range(0, 1));
        default: gray_ready = ~gray_ready;
      endcase
      if (stall_mode && wr_count == 2 && lbp_valid && stall_cnt < 5) begin
        lbp_ready = 1'b0;
        if (stall_cnt == 0) begin
          s_addr = int'(lbp_addr);
          s_data = int'(lbp_data);
        end
        if (!lbp_valid || int'(lbp_addr) != s_addr || int'(lbp_data) != s_data || gray_req)
          stall_viol++;
        stall_cnt++;
      end else begin
        lbp_ready = (l_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      #1;
      if (reset_n) begin
        if (prev_pend && (!gray_req || int'(gray_addr) != prev_addr)) hold_viol++;
        prev_pend = gray_req && !gray_ready;
        prev_addr = int'(gray_addr);
        if (lbp_valid && gray_req) pend_viol++;
        if (gray_req && gray_ready) acc_q.push_back(int'(gray_addr));
        if (lbp_valid && lbp_ready) begin
          if (wr_count == 0) first_data = int'(lbp_data);
          if (exp_q.size() == 0) begin
            check("extra_write_count", wr_count + 1, n_exp);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", 32'(lbp_addr), e.a);
            check("wr_data", 32'(lbp_data), e.d);
          end
          wr_count++;
        end
      end else begin
        prev_pend = 0;
      end
    end
  end

  task automatic start_image();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    clear_mon();
    build_expect();
    #2 reset_n = 1'b1;
  endtask

  task automatic run_image(input string tag);
    start_image();
    for (int k = 0; k < 20000 && !finish; k++) @(negedge clk);
    check({tag, ":finish"}, 32'(finish), 1);
    repeat (5) @(negedge clk);
    #2;
    check({tag, ":writes_left"}, exp_q.size(), 0);
    check({tag, ":write_count"}, wr_count, n_exp);
    check({tag, ":done_outputs"}, {finish, gray_req, lbp_valid}, 3'b100);
    check({tag, ":addr_hold"}, hold_viol, 0);
    check({tag, ":req_while_pending"}, pend_viol, 0);
  endtask

  task automatic rand_img();
    for (int i = 0; i < W * H; i++) img[i] = 8'($urandom);
  endtask

  initial begin
    int fill_seq [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int k;

    // Reset state
    reset_n = 1'b0;
    for (int i = 0; i < W * H; i++) img[i] = 8'h40;
    repeat (3) @(negedge clk);
    #2;
    check("reset_outputs", {gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish}, '0);

    // Flat image: every code 0xFF
    run_image("flat");
    check("flat:first_code", first_data, 8'hFF);

    // Known window around pixel (1,1)
    rand_img();
    img[0] = 8'h90; img[1] = 8'h10; img[2]  = 8'h80;
    img[8] = 8'h7F; img[9] = 8'h80; img[10] = 8'hFF;
    img[16] = 8'h00; img[17] = 8'h81; img[18] = 8'h80;
    run_image("pattern");
    check("pattern:first_code", first_data, 8'hD5);

    // Backpressure: third result stalled 5 cycles
    rand_img();
    stall_mode = 1;
    run_image("stall");
    check("stall:cycles", stall_cnt, 5);
    check("stall:addr", s_addr, 11);
    check("stall:held", stall_viol, 0);
    stall_mode = 0;

    // Source toggling ready every cycle
    rand_img();
    g_mode = 2;
    run_image("toggle");
    check("toggle:accepted", acc_q.size() >= 9, 1);
    if (acc_q.size() >= 9)
      for (int i = 0; i < 9; i++) check($sformatf("toggle:fill_addr%0d", i), acc_q[i], fill_seq[i]);
    g_mode = 0;

    // Reset in the middle of a SHIFT on window row 2
    rand_img();
    start_image();
    k = 0;
    while (k < 5000 && !(wr_count >= 13 && gray_req)) begin
      @(negedge clk);
      #2;
      k++;
    end
    check("midreset:reached_shift", k < 5000, 1);
    #2 reset_n = 1'b0;
    #1;
    check("midreset:outputs", {gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish}, '0);
    rand_img();
    run_image("rerun");

    // Random images with random handshakes on both sides
    for (int t = 0; t < 2; t++) begin
      rand_img();
      g_mode = 1;
      l_mode = 1;
      run_image($sformatf("random%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
